// File: rtl/lsu_apb_master.sv
// Load/store unit that turns one RV32I core data access into one APB transfer,
// handling byte-lane steering, strobes, load extension, misalignment and timeout.
module lsu_apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  func3_q;
    logic [1:0]  lane_q;
    logic [31:0] wait_cnt;

    logic        accept;
    logic        abort;
    logic        size_ok;
    logic        req_legal;
    logic [31:0] wdata_lanes;
    logic [3:0]  strb_lanes;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // Request legality: funct3 must name a real access and the address must fit its size.
    always_comb begin
        size_ok = 1'b0;
        case (req_func3[1:0])
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~req_addr[0];
            2'b10:   size_ok = (req_addr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
        req_legal = size_ok && (req_we ? ~req_func3[2] : (req_func3 != 3'b110));
    end

    always_comb begin
        wdata_lanes = 32'h0;
        strb_lanes  = 4'b0000;
        if (req_we) begin
            case (req_func3[1:0])
                2'b00: begin
                    wdata_lanes = {4{req_wdata[7:0]}};
                    strb_lanes  = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    wdata_lanes = {2{req_wdata[15:0]}};
                    strb_lanes  = 4'b0011 << {req_addr[1], 1'b0};
                end
                default: begin
                    wdata_lanes = req_wdata;
                    strb_lanes  = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        load_byte = PRDATA[{lane_q, 3'b000} +: 8];
        load_half = PRDATA[{lane_q[1], 4'b0000} +: 16];
        case (func3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = PRDATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_legal ? SETUP : DONE;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_next = DONE;
                end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs are registered from the next state so the bus sees clean levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            PADDR    <= 32'h0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PWDATA   <= 32'h0;
            PSTRB    <= 4'b0000;
            func3_q  <= 3'b000;
            lane_q   <= 2'b00;
            wait_cnt <= 32'h0;
        end else begin
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
            PSEL    <= (state_next == SETUP) || (state_next == ACCESS);
            PENABLE <= (state_next == ACCESS);

            if (accept) begin
                func3_q <= req_func3;
                lane_q  <= req_addr[1:0];
                if (req_legal) begin
                    PADDR  <= {req_addr[31:2], 2'b00};
                    PWRITE <= req_we;
                    PWDATA <= wdata_lanes;
                    PSTRB  <= strb_lanes;
                end else begin
                    err   <= 1'b1;
                    rdata <= 32'h0;
                end
            end

            if (state == SETUP) begin
                wait_cnt <= 32'h0;
            end

            // Stores report zero data; slave errors and timeouts also force zero.
            if (state == ACCESS) begin
                if (PREADY) begin
                    err   <= PSLVERR;
                    rdata <= (PSLVERR || PWRITE) ? 32'h0 : load_ext;
                end else begin
                    wait_cnt <= wait_cnt + 32'h1;
                    if (abort) begin
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Scoreboard bench for lsu_apb_master: directed core accesses against a scripted
// APB slave, with a monitor checking every completion against queued expectations.
module tb_lsu_apb_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          check_rdata;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   cycle       = 0;

    lsu_apb_master #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("done_err", {31'h0, err}, {31'h0, e.err});
                if (e.check_rdata) check_output("done_rdata", rdata, e.rdata);
            end
        end
    end

    // One core access. wait_cycles is how many ACCESS cycles PREADY stays low.
    task automatic apply_stimulus(
        input string       name,
        input logic        we,
        input logic [2:0]  func3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] slave_rdata,
        input int          wait_cycles,
        input logic        slave_err,
        input bit          legal,
        input logic        exp_err,
        input logic [31:0] exp_rdata,
        input int          exp_latency,
        input int          exp_penable,
        input logic [31:0] exp_pwdata,
        input logic [3:0]  exp_pstrb
    );
        int   start;
        int   pen_count;
        bit   stable;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = func3;
        req_addr  = addr;
        req_wdata = wdata;
        e.err         = exp_err;
        e.rdata       = exp_rdata;
        e.check_rdata = !we;
        exp_q.push_back(e);
        start = cycle;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (legal) begin
            check_output({name, "_setup_psel"}, {30'h0, PSEL, PENABLE}, 32'd2);
            check_output({name, "_paddr"}, PADDR, {addr[31:2], 2'b00});
            check_output({name, "_pwrite"}, {31'h0, PWRITE}, {31'h0, we});
            check_output({name, "_pstrb"}, {28'h0, PSTRB}, {28'h0, exp_pstrb});
            if (we) check_output({name, "_pwdata"}, PWDATA, exp_pwdata);
            @(posedge clk);
            #1;
            pen_count = 0;
            stable    = 1'b1;
            while (PENABLE === 1'b1 && pen_count < 64) begin
                if (PSEL !== 1'b1 || PADDR !== {addr[31:2], 2'b00} || PWRITE !== we ||
                    PSTRB !== exp_pstrb || (we && PWDATA !== exp_pwdata)) stable = 1'b0;
                PREADY  = (pen_count >= wait_cycles);
                PRDATA  = slave_rdata;
                PSLVERR = slave_err;
                pen_count++;
                @(posedge clk);
                #1;
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            check_output({name, "_access_stable"}, {31'h0, stable}, 32'd1);
            check_output({name, "_penable_cycles"}, pen_count, exp_penable);
            check_output({name, "_psel_after"}, {31'h0, PSEL}, 32'd0);
        end else begin
            check_output({name, "_no_psel"}, {31'h0, PSEL}, 32'd0);
        end
        check_output({name, "_done_latency"}, {31'h0, done}, 32'd1);
        check_output({name, "_latency"}, cycle - start, exp_latency);
        @(posedge clk);
        #1;
        check_output({name, "_done_pulse"}, {30'h0, done, busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ctrl", {26'h0, busy, done, err, PSEL, PENABLE, PWRITE}, 32'd0);
        check_output("reset_rdata", rdata, 32'h0);
        check_output("reset_paddr", PADDR, 32'h0);
        check_output("reset_pstrb", {28'h0, PSTRB}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //             name   we    f3     addr          wdata         prdata        wt sl lg er  exp_rdata     lat pen pwdata        pstrb
        apply_stimulus("lb",  1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 1, 0, 32'hFFFF_FF80, 3, 1,  32'h0,        4'b0000);
        apply_stimulus("sh",  1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 0, 32'h0,        3, 1,  32'hBEEF_BEEF, 4'b1100);
        apply_stimulus("lw_mis", 1'b0, 3'd2, 32'h0000_3001, 32'h0,     32'h0,        0, 0, 0, 1, 32'h0,        1, 0,  32'h0,        4'b0000);
        apply_stimulus("lhu", 1'b0, 3'd5, 32'h0000_4002, 32'h0,        32'hABCD_0000, 3, 0, 1, 0, 32'h0000_ABCD, 6, 4, 32'h0,        4'b0000);
        apply_stimulus("sw_to", 1'b1, 3'd2, 32'h0000_5000, 32'h1234_5678, 32'h0,      1000, 0, 1, 1, 32'h0,     18, 16, 32'h1234_5678, 4'b1111);
        apply_stimulus("lw_slverr", 1'b0, 3'd2, 32'h0000_6000, 32'h0,  32'h5555_AAAA, 0, 1, 1, 1, 32'h0,        3, 1,  32'h0,        4'b0000);
        apply_stimulus("sb",  1'b1, 3'd0, 32'h0000_7001, 32'h0000_00A5, 32'h0,        1, 0, 1, 0, 32'h0,        4, 2,  32'hA5A5_A5A5, 4'b0010);
        apply_stimulus("lh",  1'b0, 3'd1, 32'h0000_8002, 32'h0,        32'h8001_0000, 0, 0, 1, 0, 32'hFFFF_8001, 3, 1,  32'h0,        4'b0000);
        apply_stimulus("lw",  1'b0, 3'd2, 32'h0000_9000, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 0, 32'hCAFE_F00D, 3, 1,  32'h0,        4'b0000);
        apply_stimulus("st_f3", 1'b1, 3'd3, 32'h0000_A000, 32'h0,      32'h0,        0, 0, 0, 1, 32'h0,        1, 0,  32'h0,        4'b0000);
        apply_stimulus("ld_f3", 1'b0, 3'd6, 32'h0000_B000, 32'h0,      32'h0,        0, 0, 0, 1, 32'h0,        1, 0,  32'h0,        4'b0000);

        // Abandon a load in ACCESS by reset; no completion may appear for it.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'd2;
        req_addr  = 32'h0000_0020;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("pre_reset_access", {30'h0, PSEL, PENABLE}, 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_reset", {29'h0, PSEL, PENABLE, busy}, 32'd0);
        check_output("mid_reset_done", {31'h0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus("lbu", 1'b0, 3'd4, 32'h0000_0010, 32'h0,        32'h0000_00F0, 0, 0, 1, 0, 32'h0000_00F0, 3, 1,  32'h0,        4'b0000);

        repeat (3) @(posedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
